// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store memory master.
// Sizes, FSM states and base byte-lane patterns live here.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_e;

  localparam logic [3:0] LANES_BYTE = 4'b0001;
  localparam logic [3:0] LANES_HALF = 4'b0011;
  localparam logic [3:0] LANES_WORD = 4'b1111;

  function automatic logic [3:0] base_lanes(
    input logic [1:0] size
  );
    logic [3:0] l;
    l = 4'b0000;
    unique case (1'b1)
      (size == SZ_BYTE): l = LANES_BYTE;
      (size == SZ_HALF): l = LANES_HALF;
      (size == SZ_WORD): l = LANES_WORD;
      default:           l = 4'b0000;
    endcase
    return l;
  endfunction

  function automatic logic [7:0] lanes8(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return {4'b0000, base_lanes(size)} << off;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake plus data-memory bus of the LSU.
// master = LSU side, slave = execute stage and memory side.
interface lsu_mem_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        mem_cs;
  logic        mem_wr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_cs, mem_wr, mem_mask,
    output mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_cs, mem_wr, mem_mask,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Lane mask / store-data shifting and load-data alignment with extension.
// Purely combinational; i_rd carries {word1[23:0], word0}.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [55:0] i_rd,
  output logic [7:0]  o_mask8,
  output logic [63:0] o_wdata64,
  output logic        o_split,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lo;

  assign o_mask8   = lanes8(i_size, i_off);
  assign o_split   = |o_mask8[7:4];
  assign o_wdata64 = {32'h0, i_wdata} << {i_off, 3'b000};

  // Only 3 bytes of the second word can ever reach the low 32 bits
  always_comb begin
    w_lo = i_rd[31:0];
    unique case (i_off)
      2'd0: w_lo = i_rd[31:0];
      2'd1: w_lo = i_rd[39:8];
      2'd2: w_lo = i_rd[47:16];
      2'd3: w_lo = i_rd[55:24];
      default: w_lo = i_rd[31:0];
    endcase
  end

  always_comb begin
    o_rdata = w_lo;
    unique case (1'b1)
      (i_size == SZ_BYTE):
        o_rdata = i_unsigned ? {24'h0, w_lo[7:0]}
                             : {{24{w_lo[7]}}, w_lo[7:0]};
      (i_size == SZ_HALF):
        o_rdata = i_unsigned ? {16'h0, w_lo[15:0]}
                             : {{16{w_lo[15]}}, w_lo[15:0]};
      default: o_rdata = w_lo;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request, one or two word accesses,
// one-cycle response. Bus outputs decode from state so reset idles them.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input logic               clk,
  input logic               rst,
  lsu_mem_master_if.master  bus
);

  localparam logic [30:0] W_DEPTH = 31'(DEPTH);

  state_e      r_state;
  state_e      w_next;
  logic        r_we;
  logic        r_uns;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [29:0] r_w;
  logic [31:0] r_wdata;
  logic [31:0] r_word0;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [29:0] w_req_w;
  logic [7:0]  w_req_mask8;
  logic        w_req_bad;
  logic [7:0]  w_mask8;
  logic [63:0] w_wdata64;
  logic        w_split;
  logic [31:0] w_rdata;
  logic [31:0] w_w0;
  logic [23:0] w_w1;
  logic        w_done;

  assign w_req_w     = bus.req_addr[31:2];
  assign w_req_mask8 = lanes8(bus.req_size,
                              bus.req_addr[1:0]);
  // Reject before any access so a split store never half-commits
  assign w_req_bad =
    (bus.req_size == 2'd3) ||
    ({1'b0, w_req_w} >= W_DEPTH) ||
    ((|w_req_mask8[7:4]) &&
     (({1'b0, w_req_w} + 31'd1) >= W_DEPTH));

  assign w_w0 = (r_state == ACC0) ? bus.mem_rdata
                                  : r_word0;
  assign w_w1 = (r_state == ACC1) ? bus.mem_rdata[23:0]
                                  : 24'h0;
  assign w_done = ((r_state == ACC0) && !w_split) ||
                  (r_state == ACC1);

  lsu_align u_align (
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .i_rd       ({w_w1, w_w0}),
    .o_mask8    (w_mask8),
    .o_wdata64  (w_wdata64),
    .o_split    (w_split),
    .o_rdata    (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_cs    = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_mask  = 4'h0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          w_next = w_req_bad ? RESP : ACC0;
      end
      ACC0: begin
        bus.mem_cs    = 1'b0;
        bus.mem_wr    = ~r_we;
        bus.mem_mask  = w_mask8[3:0];
        bus.mem_addr  = {2'b00, r_w};
        bus.mem_wdata = r_we ? w_wdata64[31:0]
                             : 32'h0;
        w_next = w_split ? ACC1 : RESP;
      end
      ACC1: begin
        bus.mem_cs    = 1'b0;
        bus.mem_wr    = ~r_we;
        bus.mem_mask  = w_mask8[7:4];
        bus.mem_addr  = {2'b00, r_w + 30'd1};
        bus.mem_wdata = r_we ? w_wdata64[63:32]
                             : 32'h0;
        w_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'd0;
      r_off   <= 2'd0;
      r_w     <= '0;
      r_wdata <= '0;
      r_word0 <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == IDLE) && bus.req_valid) begin
        r_we    <= bus.req_we;
        r_uns   <= bus.req_unsigned;
        r_size  <= bus.req_size;
        r_off   <= bus.req_addr[1:0];
        r_w     <= w_req_w;
        r_wdata <= bus.req_wdata;
        if (w_req_bad) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
      if (r_state == ACC0)
        r_word0 <= bus.mem_rdata;
      if (w_done) begin
        r_err   <= 1'b0;
        r_rdata <= r_we ? 32'h0 : w_rdata;
      end
    end
  end

  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
